// File: rtl/kp_pkg.sv
// -----------------------------------------------------------------------------
// kp_pkg
//   Shared constants and types for the keypad selector FIFO.
//   Contents:
//     KP_WIDTH      default bits per channel value
//     KP_NCH        default number of keypad channels (0-9, star, sharp)
//     KP_SEL_W      default key code width
//     KP_DEPTH      default FIFO depth
//     KP_KEY_STAR   key code of the star key
//     KP_KEY_SHARP  key code of the sharp key
//     kp_entry_t    one queued event at default widths: {code, value}
// -----------------------------------------------------------------------------
package kp_pkg;

    localparam int KP_WIDTH = 4;
    localparam int KP_NCH   = 12;
    localparam int KP_SEL_W = 4;
    localparam int KP_DEPTH = 4;

    localparam logic [KP_SEL_W-1:0] KP_KEY_STAR  = 4'd10;
    localparam logic [KP_SEL_W-1:0] KP_KEY_SHARP = 4'd11;

    typedef struct packed {
        logic [KP_SEL_W-1:0] code;
        logic [KP_WIDTH-1:0] value;
    } kp_entry_t;

endpackage : kp_pkg

// File: rtl/kp_sync_fifo.sv
// -----------------------------------------------------------------------------
// kp_sync_fifo
//   Single-clock FIFO with a registered head. Full/empty is decided by the
//   occupancy counter only; pointers wrap modulo DEPTH.
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   synchronous active-high reset
//     push_i     in   write request (dropped when full and no pop)
//     pop_i      in   consumer ready; ignored while empty
//     wr_data_i  in   EW-bit entry to write
//     rd_valid_o out  head is valid (count != 0)
//     rd_data_o  out  head entry; holds last popped entry when empty
//     count_o    out  occupancy, 0..DEPTH
//     full_o     out  count == DEPTH
// -----------------------------------------------------------------------------
module kp_sync_fifo #(
    parameter int EW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [EW-1:0]            wr_data_i,
    output logic                     rd_valid_o,
    output logic [EW-1:0]            rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] head_q, head_d;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop_i && !empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO
        // is still accepted then.
        do_push  = push_i && (!full || do_pop);

        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end

        // The head register tracks mem[rd_ptr] after this edge. If that slot
        // is the one being written right now, take the incoming data. When
        // the FIFO becomes empty the head keeps the entry just popped.
        head_d = head_q;
        if (count_d != '0) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = wr_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_valid_o = !empty;
    assign rd_data_o  = head_q;
    assign count_o    = count_q;
    assign full_o     = full;

endmodule : kp_sync_fifo

// File: rtl/keypad_sel_fifo.sv
// -----------------------------------------------------------------------------
// keypad_sel_fifo
//   Registered keypad value selector. On each sel_valid strobe the channel
//   addressed by sel_code is picked from the flat d_in bus and queued with its
//   code; the queue drains over a valid/ready port.
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   synchronous active-high reset, wins over all events
//     sel_valid  in   key event strobe, one cycle per event
//     sel_code   in   channel index of the event
//     d_in       in   flat channel bus, channel k = d_in[k*WIDTH +: WIDTH]
//     out_valid  out  head entry valid
//     out_ready  in   consumer accepts head this cycle
//     out_data   out  head value
//     out_code   out  head key code
//     count      out  FIFO occupancy, 0..DEPTH
//     err_code   out  1-cycle pulse: previous event had sel_code >= NCH
//     overflow   out  1-cycle pulse: previous valid event dropped (full)
//
//   Handshake: the head transfers on a rising edge where out_valid and
//   out_ready are both 1; out_valid never depends on out_ready, out_ready
//   while out_valid=0 is ignored, and the head holds stable until it
//   transfers. The next entry is presented in the following cycle.
// -----------------------------------------------------------------------------
module keypad_sel_fifo
    import kp_pkg::*;
#(
    parameter int WIDTH = KP_WIDTH,
    parameter int NCH   = KP_NCH,
    parameter int SEL_W = KP_SEL_W,   // 2**SEL_W must be >= NCH
    parameter int DEPTH = KP_DEPTH    // power of two, >= 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel_code,
    input  logic [NCH*WIDTH-1:0]    d_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_code,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err_code,
    output logic                    overflow
);

    localparam int EW = SEL_W + WIDTH;

    logic             code_ok;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic [WIDTH-1:0] sel_value;
    logic [EW-1:0]    head;

    logic err_q, err_d;
    logic ovf_q, ovf_d;

    // Unsigned range check done at 32 bits so NCH == 2**SEL_W also works.
    assign code_ok = ({{(32-SEL_W){1'b0}}, sel_code} < 32'(NCH));

    // Explicit mux rather than a variable part-select, so an out-of-range
    // code never indexes past the end of d_in.
    always_comb begin
        sel_value = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_code == SEL_W'(k)) begin
                sel_value = d_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign push = sel_valid && code_ok;
    assign pop  = out_valid && out_ready;

    always_comb begin
        err_d = sel_valid && !code_ok;
        // A bad code never reports overflow; a full FIFO only drops the event
        // when nothing is popped in the same cycle.
        ovf_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            err_q <= err_d;
            ovf_q <= ovf_d;
        end
    end

    kp_sync_fifo #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (out_ready),
        .wr_data_i  ({sel_code, sel_value}),
        .rd_valid_o (out_valid),
        .rd_data_o  (head),
        .count_o    (count),
        .full_o     (fifo_full)
    );

    assign out_code = head[EW-1:WIDTH];
    assign out_data = head[WIDTH-1:0];
    assign err_code = err_q;
    assign overflow = ovf_q;

endmodule : keypad_sel_fifo

// File: tb/tb_keypad_sel_fifo.sv
// -----------------------------------------------------------------------------
// tb_keypad_sel_fifo
//   Bench for keypad_sel_fifo at default parameters. A queue of kp_entry_t
//   models the FIFO contents; the last popped entry models the held head.
// -----------------------------------------------------------------------------
module tb_keypad_sel_fifo;
    import kp_pkg::*;

    localparam int W  = KP_WIDTH;
    localparam int N  = KP_NCH;
    localparam int SW = KP_SEL_W;
    localparam int D  = KP_DEPTH;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst       = 1'b1;
    logic              sel_valid = 1'b0;
    logic [SW-1:0]     sel_code  = '0;
    logic [N*W-1:0]    d_in      = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_code;
    logic [$clog2(D):0] count;
    logic              err_code;
    logic              overflow;

    keypad_sel_fifo #(
        .WIDTH (W),
        .NCH   (N),
        .SEL_W (SW),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_valid (sel_valid),
        .sel_code  (sel_code),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_code  (out_code),
        .count     (count),
        .err_code  (err_code),
        .overflow  (overflow)
    );

    // scoreboard / reference model
    kp_entry_t exp_q[$];
    kp_entry_t last_pop;
    logic      exp_err;
    logic      exp_ovf;
    int        n_checks = 0;
    int        n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model one clock edge from the rules: reset clears everything; a bad
    // code pulses err; a good code is queued unless full without a pop.
    task automatic model_edge(input logic r, input logic sv, input logic [SW-1:0] c,
                              input logic [N*W-1:0] din, input logic rdy);
        logic pop, good, bad, full;
        kp_entry_t e;
        if (r) begin
            exp_q.delete();
            last_pop = '0;
            exp_err  = 1'b0;
            exp_ovf  = 1'b0;
        end else begin
            pop  = rdy && (exp_q.size() > 0);
            bad  = sv && (int'(c) >= N);
            good = sv && !bad;
            full = (exp_q.size() == D);
            exp_err = bad;
            exp_ovf = good && full && !pop;
            if (pop) last_pop = exp_q.pop_front();
            if (good && (!full || pop)) begin
                e.code  = c;
                e.value = din[int'(c)*W +: W];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        kp_entry_t h;
        h = (exp_q.size() > 0) ? exp_q[0] : last_pop;
        chk({tag, ".valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
        chk({tag, ".count"}, 32'(count),     32'(exp_q.size()));
        chk({tag, ".data"},  32'(out_data),  32'(h.value));
        chk({tag, ".code"},  32'(out_code),  32'(h.code));
        chk({tag, ".err"},   32'(err_code),  32'(exp_err));
        chk({tag, ".ovf"},   32'(overflow),  32'(exp_ovf));
    endtask

    // driver: apply inputs on the falling edge, check 1 time unit after rise
    task automatic step(input string tag, input logic r, input logic sv,
                        input logic [SW-1:0] c, input logic [N*W-1:0] din,
                        input logic rdy);
        @(negedge clk);
        rst = r; sel_valid = sv; sel_code = c; d_in = din; out_ready = rdy;
        model_edge(r, sv, c, din, rdy);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [N*W-1:0] din_with(input int ch, input logic [W-1:0] v);
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom_range(0, 15));
        if (ch < N) d[ch*W +: W] = v;
        return d;
    endfunction

    function automatic logic [N*W-1:0] din_rand();
        return din_with(N, '0);
    endfunction

    int codes2[4]  = '{10, 11, 0, 7};
    int vals2[4]   = '{5, 6, 1, 9};

    initial begin
        last_pop = '0;
        exp_err  = 1'b0;
        exp_ovf  = 1'b0;

        // reset state
        step("rst0", 1, 0, 0, '0, 0);
        step("rst1", 1, 1, 3, din_rand(), 1);
        step("idle", 0, 0, 0, din_rand(), 0);

        // single push with code 3, channel 3 = A
        step("t1", 0, 1, 3, din_with(3, 4'hA), 0);
        chk("t1_data_const", 32'(out_data), 32'hA);
        chk("t1_code_const", 32'(out_code), 32'd3);
        step("t1_drain", 0, 0, 0, din_rand(), 1);

        // fill with star, sharp, 0, 7 then drain in order
        for (int i = 0; i < 4; i++)
            step("t2_push", 0, 1, SW'(codes2[i]), din_with(codes2[i], W'(vals2[i])), 0);
        chk("t2_full_const", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order_data", 32'(out_data), 32'(vals2[i]));
            step("t2_pop", 0, 0, 0, din_rand(), 1);
        end

        // full: drop without pop, accept with pop
        for (int i = 0; i < 4; i++)
            step("t3_fill", 0, 1, SW'(i + 4), din_rand(), 0);
        step("t3_drop", 0, 1, 2, din_with(2, 4'h3), 0);
        chk("t3_ovf_const", 32'(overflow), 32'd1);
        step("t3_after", 0, 0, 0, din_rand(), 0);
        step("t3_accept", 0, 1, 2, din_with(2, 4'hC), 1);
        for (int i = 0; i < 4; i++)
            step("t3_drain", 0, 0, 0, din_rand(), 1);
        chk("t3_last_code_const", 32'(out_code), 32'd2);

        // bad codes, including while full
        step("t4_c12", 0, 1, 12, din_rand(), 0);
        step("t4_c15", 0, 1, 15, din_rand(), 0);
        for (int i = 0; i < 4; i++)
            step("t4_fill", 0, 1, SW'(i), din_rand(), 0);
        step("t4_c13_full", 0, 1, 13, din_rand(), 0);
        step("t4_idle", 0, 0, 0, din_rand(), 0);
        for (int i = 0; i < 4; i++)
            step("t4_drain", 0, 0, 0, din_rand(), 1);

        // push/pop pairs to wrap the pointers, then reset mid-stream
        for (int i = 0; i < 8; i++)
            step("t5_pair", 0, 1, SW'($urandom_range(0, N - 1)), din_rand(), 1);
        step("t5_fill", 0, 1, 9, din_rand(), 0);
        step("t5_rst", 1, 1, 5, din_rand(), 1);
        chk("t5_valid_const", 32'(out_valid), 32'd0);
        chk("t5_data_const",  32'(out_data),  32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 59) == 0);
            step("rand", r, 1'($urandom_range(0, 1)), SW'($urandom_range(0, 15)),
                 din_rand(), ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // bound on total run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors %0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule : tb_keypad_sel_fifo
